// File: rtl/cs_pkg.sv
// Shared definitions for the computational-system (CS) result path.
package cs_pkg;

    localparam int CS_Y_W = 10;  // width of the CS result Y
    localparam int CS_X_W = 8;   // width of the CS input samples
    localparam int CS_WIN = 9;   // CS window length in samples

    // Result-path phase: idle, priming the window, or delivering real results.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } cs_state_e;

endpackage : cs_pkg

// File: rtl/cs_fifo_mem.sv
// Storage array for the CS result FIFO: DEPTH x Y_W registers with one
// synchronous write port and one combinational read port.
module cs_fifo_mem #(
    parameter int Y_W   = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [Y_W-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [Y_W-1:0] rdata
);

    logic [Y_W-1:0] mem [DEPTH];

    // Write the incoming result into its slot.
    // NOTE: the array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : cs_fifo_mem

// File: rtl/cs_result_fifo.sv
// CS result FIFO: discards the warm-up results produced before the CS window
// is primed, then buffers every result in a first-word-fall-through FIFO with
// a valid/ready read port and a sticky overflow flag.
// Optional build macro CS_RESULT_STATS_EN adds y_min, y_max and drop_cnt.
module cs_result_fifo
    import cs_pkg::*;
#(
    parameter int Y_W   = CS_Y_W,
    parameter int WIN   = CS_WIN,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [Y_W-1:0]           in_y,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [Y_W-1:0]           out_y,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     warm
`ifdef CS_RESULT_STATS_EN
    ,
    output logic [Y_W-1:0]           y_min,
    output logic [Y_W-1:0]           y_max,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int AW     = $clog2(DEPTH);
    localparam int WCNT_W = $clog2(WIN + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN - 1);

    cs_state_e         state;
    logic [WCNT_W-1:0] wcnt;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [Y_W-1:0]    head;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic accept;
    logic drop;

    // Pointer-derived flags: equal pointers mean empty, same slot on opposite laps means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A flush cancels any push or pop in the same cycle.
    assign pop    = !empty && out_ready && !flush;
    assign push   = in_valid && !flush &&
                    ((state == ST_RUN) || ((state == ST_WARMUP) && (wcnt == WCNT_LAST)));
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign out_valid = !empty;
    assign out_y     = out_valid ? head : '0;
    assign count     = wr_ptr - rd_ptr;
    assign warm      = (state == ST_RUN);

    // Warm-up tracking: count beats since idle until the window holds WIN samples.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    state <= ST_WARMUP;
                    wcnt  <= WCNT_W'(1);
                end
                ST_WARMUP: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == WCNT_LAST) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    // Read and write pointers, each with a wrap bit above the slot index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow: set when a result is dropped on a full FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef CS_RESULT_STATS_EN
    // Running min/max of accepted results and a saturating count of dropped ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_min    <= '1;
            y_max    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            y_min    <= '1;
            y_max    <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                if (in_y < y_min) begin
                    y_min <= in_y;
                end
                if (in_y > y_max) begin
                    y_max <= in_y;
                end
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`endif

    cs_fifo_mem #(
        .Y_W   (Y_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_y),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

endmodule : cs_result_fifo
